reg_change_reader: RTL and testbench
====================================

# reg_change_reader

Capture-side reader for the 16-bit registered data path. It samples the register's `dout` word stream and detects every change of value. Each change is queued with the number of sample cycles since the previous change. A downstream consumer drains the queue over a valid/ready handshake. It is the read end of the register interface: it turns a level-held output into discrete, timestamped transactions for scoreboards and status logic.

## Interface
- `DW`, 16: data width; matches the register word width.
- `DEPTH`, 8: queue entries; power of 2, minimum 2.
- `TSW`, 16: width of the delta (cycle-gap) field.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `din` input DW: observed register output word.
- `sample_en` input 1: sample `din` this cycle when 1; hold all capture state when 0.
- `out_valid` output 1: queue head is valid.
- `out_ready` input 1: consumer accepts the head this cycle.
- `out_data` output DW: head entry's new data value.
- `out_delta` output TSW: head entry's gap in sample cycles since the previous change, saturating.
- `out_count` output $clog2(DEPTH)+1: current number of queued entries, 0..DEPTH.
- `overflow` output 1: sticky; set when a change was dropped because the queue was full.
- `clr_overflow` input 1: clears `overflow`.

## Operation
- Internal `last` register (DW) holds the last captured value. `last` resets to 0, which is the register's own reset value, so no entry is produced for the post-reset zero.
- Internal gap counter `gap` (TSW) resets to 0.
- A change is a cycle with `sample_en`=1 and `din` != `last`.
- On a change:
  - The entry {`din`, sat(`gap`+1)} is pushed.
  - `last` <= `din`.
  - `gap` <= 0.
- On a `sample_en` cycle with no change, `gap` <= sat(`gap`+1). Saturation holds at 2^TSW-1 and never wraps.
- When `sample_en`=0, `last` and `gap` hold.
- Queue: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count.
- Pop: `out_valid` && `out_ready`.
- Push with the queue not full is accepted.
- Push with the queue full and a pop in the same cycle is accepted. Occupancy stays DEPTH and both pointers advance.
- Push with the queue full and no pop: the entry is dropped. `overflow` <= 1, and `last`/`gap` update as for a normal change, so the change is lost and not retried.
- `out_ready` with an empty queue has no effect.
- `overflow`: set has priority over `clr_overflow` in the same cycle. Otherwise `clr_overflow` clears it.
- Output is first-word-fall-through:
  - `out_valid` = (count != 0).
  - `out_data` and `out_delta` always show the head entry.
  - `out_data` and `out_delta` must stay stable while `out_valid` && !`out_ready`.
- Reset (`rst`=1 at an edge) clears the pointers, count, `last`, `gap` and `overflow`. It discards queued entries, including mid-handshake. Any change presented in the reset cycle is ignored.

## Timing
- Reset values: `out_valid`=0, `out_count`=0, `overflow`=0. `out_data` and `out_delta` are don't-care while `out_valid`=0; the bench must not check them.
- Capture latency:
  - A change sampled at edge N makes `out_valid`=1 and `out_count` update after edge N, visible in cycle N+1.
  - The register's own one-cycle delay is upstream and not counted here.
- Pop: the head advances at the edge where `out_valid` && `out_ready`. The next entry is visible the following cycle.
- Throughput: one push and one pop per cycle. Sustained back-to-back changes at full rate with `out_ready`=1 never overflow.
- `out_count` is registered; it reflects the pushes and pops of the previous edge.
- No combinational path from `out_ready` to `out_valid`, `out_data` or `out_delta`. Output data comes from memory read at the registered read pointer.

## Test plan
- Reset then steady `din`:
  - Stimulus: `rst` for 2 cycles, then `din`=0 with `sample_en`=1 for 20 cycles.
  - Required: `out_valid`=0 and `out_count`=0 throughout.
- Single change and gap:
  - Stimulus: after reset, `din`=0 for 4 sample cycles, then `din`=16'h1234.
  - Required: one entry {16'h1234, 5}. `out_valid` rises the cycle after the change is sampled.
  - Follow-up: drive 16'hABCD three sample cycles later. Required: entry {16'hABCD, 3}.
- Full queue and overflow:
  - Stimulus: `out_ready`=0, then 9 distinct consecutive values, each with delta 1.
  - Required: `out_count`=8 and `overflow`=1. Draining yields the first 8 values in order and the 9th is absent.
  - Follow-up: `clr_overflow` and a new overflow in the same cycle. Required: `overflow` stays 1.
- Full queue with simultaneous push/pop:
  - Stimulus: queue at DEPTH, then `out_ready`=1 in the same cycle as a new change 16'h5555.
  - Required: `out_count` stays 8, no overflow, and 16'h5555 appears as the last entry.
- Gap saturation and `sample_en` gating:
  - Stimulus: TSW=4, hold `din` for 30 sample cycles, then change. Required: delta=15.
  - Stimulus: toggle `din` while `sample_en`=0. Required: no entries and `gap` frozen.
- Reset mid-operation:
  - Stimulus: 5 entries queued, `out_valid`=1 and `out_ready`=1, then `rst` asserted.
  - Required: next cycle `out_valid`=0 and `out_count`=0. A first post-reset change to 16'h0001 after 2 sample cycles yields {16'h0001, 3}.

Source files
------------

// File: rtl/reg_change_reader.sv
// reg_change_reader
// Watches the level-held output word of a register and turns every change of
// value into a queued transaction {new value, sample cycles since the previous
// change}. A downstream consumer drains the queue over valid/ready.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   din          - observed register output word (DW bits)
//   sample_en    - sample din this cycle; capture state holds when low
//   out_valid    - queue head is valid (first-word-fall-through)
//   out_ready    - consumer accepts the head this cycle
//   out_data     - head entry's new data value
//   out_delta    - head entry's saturating gap in sample cycles (TSW bits)
//   out_count    - number of queued entries, 0..DEPTH
//   overflow     - sticky, set when a change was dropped on a full queue
//   clr_overflow - clears overflow (a new drop in the same cycle wins)
module reg_change_reader #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   parameter int TSW   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DW-1:0]            din,
   input  logic                     sample_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [TSW-1:0]           out_delta,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [TSW-1:0] GAP_MAX = '1;
   localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

   logic [DW-1:0]  last;
   logic [TSW-1:0] gap;
   logic [TSW-1:0] gap_inc;

   logic [DW-1:0]  mem_data  [DEPTH];
   logic [TSW-1:0] mem_delta [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   logic change;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;

   // Change detection and queue control. A push into a full queue is still
   // accepted when the head is popped in the same cycle, because the slot
   // being written is exactly the one being vacated.
   always_comb begin
      gap_inc = (gap == GAP_MAX) ? gap : gap + 1'b1;
      change  = sample_en && (din != last);
      pop     = out_valid && out_ready;
      full    = (count == FULL_COUNT);
      push_ok = change && (!full || pop);
      drop    = change && full && !pop;
   end

   // Capture state, pointers, occupancy and the sticky overflow flag. A
   // dropped change still advances last/gap so it is lost rather than
   // retried on the next sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         last     <= '0;
         gap      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (change) begin
            last <= din;
            gap  <= '0;
         end else if (sample_en) begin
            gap <= gap_inc;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Entry storage. The delta stored is the gap including the change cycle
   // itself, saturated at the field maximum.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem_data[wr_ptr]  <= din;
         mem_delta[wr_ptr] <= gap_inc;
      end
   end

   // Head of the queue is read straight from storage at the registered read
   // pointer, so out_ready never reaches the outputs combinationally.
   always_comb begin
      out_valid = (count != '0);
      out_count = count;
      out_data  = mem_data[rd_ptr];
      out_delta = mem_delta[rd_ptr];
   end

endmodule

// File: tb/tb_reg_change_reader.sv
// tb_reg_change_reader
// Scoreboard bench for reg_change_reader. Expected entries are queued when a
// change is driven and compared when the DUT hands them over at a handshake.
// A second instance with a 4-bit delta field exercises gap saturation.
module tb_reg_change_reader;

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic        sampleEn;
   logic        outValid;
   logic        outReady;
   logic [15:0] outData;
   logic [15:0] outDelta;
   logic [3:0]  outCount;
   logic        overflow;
   logic        clrOverflow;

   logic [15:0] dinB;
   logic        sampleEnB;
   logic        outValidB;
   logic        outReadyB;
   logic [15:0] outDataB;
   logic [3:0]  outDeltaB;
   logic [3:0]  outCountB;
   logic        overflowB;
   logic        clrOverflowB;

   int errors;
   int checks;
   logic [31:0] sb [$];
   logic [31:0] sbHead;

   reg_change_reader #(.DW(16), .DEPTH(8), .TSW(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .sample_en    (sampleEn),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .out_data     (outData),
      .out_delta    (outDelta),
      .out_count    (outCount),
      .overflow     (overflow),
      .clr_overflow (clrOverflow)
   );

   reg_change_reader #(.DW(16), .DEPTH(8), .TSW(4)) dutSat (
      .clk          (clk),
      .rst          (rst),
      .din          (dinB),
      .sample_en    (sampleEnB),
      .out_valid    (outValidB),
      .out_ready    (outReadyB),
      .out_data     (outDataB),
      .out_delta    (outDeltaB),
      .out_count    (outCountB),
      .overflow     (overflowB),
      .clr_overflow (clrOverflowB)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive the main instance's inputs and advance one clock edge; outputs
   // are then sampled 1 unit after the edge
   task automatic applyStimulus(input logic [15:0] d, input logic se, input logic rdy, input logic clr);
      din         = d;
      sampleEn    = se;
      outReady    = rdy;
      clrOverflow = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic expectEntry(input logic [15:0] d, input logic [15:0] delta);
      sb.push_back({d, delta});
   endtask

   // Handshake monitor: inputs are stable between their drive point and the
   // next rising edge, so a handshake seen here is the one the edge accepts
   always @(negedge clk) begin
      if (!rst && outValid && outReady) begin
         checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            sbHead = sb.pop_front();
            checkOutput("pop_data", 32'(outData), 32'(sbHead[31:16]));
            checkOutput("pop_delta", 32'(outDelta), 32'(sbHead[15:0]));
         end
      end
   end

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      din          = '0;
      sampleEn     = 1'b0;
      outReady     = 1'b0;
      clrOverflow  = 1'b0;
      dinB         = '0;
      sampleEnB    = 1'b0;
      outReadyB    = 1'b0;
      clrOverflowB = 1'b0;

      // Reset then steady zero input: nothing is ever queued
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      checkOutput("rst_valid", 32'(outValid), 32'd0);
      checkOutput("rst_count", 32'(outCount), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0);
         checkOutput("steady_valid", 32'(outValid), 32'd0);
         checkOutput("steady_count", 32'(outCount), 32'd0);
      end

      // Single change after four zero samples, then a second change
      rst = 1'b1;
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("pre_change_valid", 32'(outValid), 32'd0);
      expectEntry(16'h1234, 16'd5);
      applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0);
      checkOutput("change_valid", 32'(outValid), 32'd1);
      checkOutput("change_count", 32'(outCount), 32'd1);
      applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0);
      expectEntry(16'hABCD, 16'd3);
      applyStimulus(16'hABCD, 1'b1, 1'b0, 1'b0);
      checkOutput("two_count", 32'(outCount), 32'd2);
      checkOutput("head_data_held", 32'(outData), 32'h1234);
      checkOutput("head_delta_held", 32'(outDelta), 32'd5);
      applyStimulus(16'hABCD, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'hABCD, 1'b0, 1'b1, 1'b0);
      checkOutput("drain1_valid", 32'(outValid), 32'd0);

      // Fill the queue, overflow on the ninth value
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) begin
            expectEntry(16'h0100 + 16'(i), 16'd1);
         end
         applyStimulus(16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0);
         if (i == 8) begin
            checkOutput("fill_count", 32'(outCount), 32'd8);
            checkOutput("fill_overflow", 32'(overflow), 32'd0);
         end
      end
      checkOutput("ovf_count", 32'(outCount), 32'd8);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      applyStimulus(16'h0200, 1'b1, 1'b0, 1'b1);
      checkOutput("ovf_set_beats_clr", 32'(overflow), 32'd1);
      applyStimulus(16'h0200, 1'b0, 1'b0, 1'b1);
      checkOutput("ovf_cleared", 32'(overflow), 32'd0);

      // Push and pop together on a full queue
      expectEntry(16'h5555, 16'd1);
      applyStimulus(16'h5555, 1'b1, 1'b1, 1'b0);
      checkOutput("pushpop_count", 32'(outCount), 32'd8);
      checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'h5555, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("drain2_valid", 32'(outValid), 32'd0);
      checkOutput("drain2_sb", 32'(sb.size()), 32'd0);

      // sample_en gating: toggling input while disabled queues nothing and
      // leaves the gap frozen at 1
      applyStimulus(16'h5555, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus((i % 2 == 0) ? 16'hF0F0 : 16'h0F0F, 1'b0, 1'b0, 1'b0);
         checkOutput("gated_count", 32'(outCount), 32'd0);
      end
      expectEntry(16'h7777, 16'd2);
      applyStimulus(16'h7777, 1'b1, 1'b0, 1'b0);
      checkOutput("gated_delta", 32'(outDelta), 32'd2);
      applyStimulus(16'h7777, 1'b0, 1'b1, 1'b0);
      checkOutput("gated_drain", 32'(outValid), 32'd0);

      // Gap saturation on the 4-bit delta instance
      sampleEnB = 1'b1;
      dinB      = 16'h0000;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(16'h7777, 1'b0, 1'b0, 1'b0);
      end
      dinB = 16'h00AA;
      applyStimulus(16'h7777, 1'b0, 1'b0, 1'b0);
      sampleEnB = 1'b0;
      checkOutput("sat_valid", 32'(outValidB), 32'd1);
      checkOutput("sat_count", 32'(outCountB), 32'd1);
      checkOutput("sat_data", 32'(outDataB), 32'h00AA);
      checkOutput("sat_delta", 32'(outDeltaB), 32'd15);

      // Reset in the middle of a handshake discards the queue
      for (int i = 1; i <= 5; i++) begin
         expectEntry(16'h0010 + 16'(i), 16'd1);
         applyStimulus(16'h0010 + 16'(i), 1'b1, 1'b0, 1'b0);
      end
      checkOutput("mid_count", 32'(outCount), 32'd5);
      rst = 1'b1;
      sb.delete();
      applyStimulus(16'h0099, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      checkOutput("midrst_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_count", 32'(outCount), 32'd0);
      applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0);
      expectEntry(16'h0001, 16'd3);
      applyStimulus(16'h0001, 1'b1, 1'b0, 1'b0);
      checkOutput("post_rst_count", 32'(outCount), 32'd1);
      checkOutput("post_rst_data", 32'(outData), 32'h0001);
      checkOutput("post_rst_delta", 32'(outDelta), 32'd3);
      applyStimulus(16'h0001, 1'b0, 1'b1, 1'b0);
      checkOutput("final_valid", 32'(outValid), 32'd0);
      checkOutput("final_sb", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
